msrh_lsu_replay_sched: RTL

Replay scheduler for one LSU pipe. It tracks which memory-queue entries are parked on a hazard: TLB miss, L1D conflict, LRQ conflict or LRQ refill. Each entry wakes when its resolving event arrives, and the block selects one ready entry per cycle round-robin. It drives the pipe's EX0 replay port (`i_ex0_replay_issue` / `i_ex0_replay_index_oh`), which always wins over the reservation-station issue.

---
 rtl/msrh_lsu_pkg.sv | 31 +++
 rtl/msrh_lsu_replay_entry.sv | 97 +++++++++
 rtl/msrh_lsu_replay_sched.sv | 110 +++++++++++
 3 files changed

// File: rtl/msrh_lsu_pkg.sv
// Shared LSU types: issue payload, EX2 hazard codes and replay entry states.
package msrh_lsu_pkg;

  localparam int unsigned MEM_Q_SIZE     = 8;
  localparam int unsigned LRQ_ENTRY_SIZE = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [5:0]  cmt_id;
    logic [1:0]  grp_id;
  } issue_t;

  typedef enum logic [1:0] {
    EX2_HAZ_NONE,
    EX2_HAZ_L1D_CONFLICT,
    EX2_HAZ_LRQ_CONFLICT,
    EX2_HAZ_LRQ_ASSIGNED
  } ex2_haz_t;

  typedef enum logic [2:0] {
    REPLAY_IDLE,
    REPLAY_WAIT_TLB,
    REPLAY_WAIT_REFILL,
    REPLAY_WAIT_LRQ_FREE,
    REPLAY_BACKOFF,
    REPLAY_READY,
    REPLAY_INFLIGHT
  } replay_state_t;

endpackage

// File: rtl/msrh_lsu_replay_entry.sv
// One memory-queue entry's replay state: hazard wait, wake-up and grant tracking.
module msrh_lsu_replay_entry
  import msrh_lsu_pkg::*;
#(
  parameter int unsigned LRQ_SIZE    = LRQ_ENTRY_SIZE,
  parameter int unsigned BACKOFF_CYC = 3
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_clear,
  input  logic                i_ex1_haz_vld,
  input  logic                i_ex2_update,
  input  ex2_haz_t            i_ex2_hazard_typ,
  input  logic [LRQ_SIZE-1:0] i_ex2_lrq_index_oh,
  input  logic                i_tlb_resolve,
  input  logic                i_lrq_resolve_vld,
  input  logic [LRQ_SIZE-1:0] i_lrq_resolve_index_oh,
  input  logic                i_lrq_free,
  input  logic                i_grant,
  output logic                o_ready
);

  localparam logic [2:0] BACKOFF_INIT = 3'(BACKOFF_CYC);

  replay_state_t       r_state, w_state_next;
  logic [LRQ_SIZE-1:0] r_mask, w_mask_next;
  logic [2:0]          r_cnt, w_cnt_next;
  logic                w_fresh_backoff;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= REPLAY_IDLE;
      r_mask  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_mask  <= w_mask_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_mask_next     = r_mask;
    w_cnt_next      = r_cnt;
    w_fresh_backoff = 1'b0;
    if (i_clear) begin
      w_state_next = REPLAY_IDLE;
      w_mask_next  = '0;
      w_cnt_next   = '0;
    end else begin
      if (i_ex1_haz_vld) begin
        w_state_next = REPLAY_WAIT_TLB;
      end else if (i_ex2_update) begin
        case (i_ex2_hazard_typ)
          EX2_HAZ_L1D_CONFLICT: begin
            w_state_next    = REPLAY_BACKOFF;
            w_cnt_next      = BACKOFF_INIT;
            w_fresh_backoff = 1'b1;
          end
          EX2_HAZ_LRQ_CONFLICT: w_state_next = REPLAY_WAIT_LRQ_FREE;
          EX2_HAZ_LRQ_ASSIGNED: begin
            w_state_next = REPLAY_WAIT_REFILL;
            w_mask_next  = i_ex2_lrq_index_oh;
          end
          default: w_state_next = REPLAY_IDLE;
        endcase
      end else if (r_state == REPLAY_READY && i_grant) begin
        w_state_next = REPLAY_INFLIGHT;
      end

      // Wake is evaluated on the post-report state so a coincident wake is not lost.
      // The report cycle counts as the first backoff cycle: READY once the count would reach 1.
      case (w_state_next)
        REPLAY_WAIT_TLB:
          if (i_tlb_resolve) w_state_next = REPLAY_READY;
        REPLAY_WAIT_REFILL:
          if (i_lrq_resolve_vld && |(w_mask_next & i_lrq_resolve_index_oh))
            w_state_next = REPLAY_READY;
        REPLAY_WAIT_LRQ_FREE:
          if (i_lrq_free) w_state_next = REPLAY_READY;
        REPLAY_BACKOFF: begin
          if (w_fresh_backoff ? (w_cnt_next <= 3'd1) : (w_cnt_next <= 3'd2)) begin
            w_state_next = REPLAY_READY;
            w_cnt_next   = '0;
          end else if (!w_fresh_backoff) begin
            w_cnt_next = w_cnt_next - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready = (r_state == REPLAY_READY);

endmodule

// File: rtl/msrh_lsu_replay_sched.sv
// LSU replay scheduler: per-entry hazard tracking, round-robin pick of one READY
// entry per cycle and a registered EX0 replay payload.
module msrh_lsu_replay_sched
  import msrh_lsu_pkg::*;
#(
  parameter int unsigned ENTRY_SIZE  = MEM_Q_SIZE,
  parameter int unsigned LRQ_SIZE    = LRQ_ENTRY_SIZE,
  parameter int unsigned BACKOFF_CYC = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  issue_t                i_entry_issue [ENTRY_SIZE],
  input  logic [ENTRY_SIZE-1:0] i_entry_clear,
  input  logic                  i_ex1_haz_vld,
  input  logic [ENTRY_SIZE-1:0] i_ex1_index_oh,
  input  logic                  i_ex2_update,
  input  logic [ENTRY_SIZE-1:0] i_ex2_index_oh,
  input  ex2_haz_t              i_ex2_hazard_typ,
  input  logic [LRQ_SIZE-1:0]   i_ex2_lrq_index_oh,
  input  logic                  i_tlb_resolve,
  input  logic                  i_lrq_resolve_vld,
  input  logic [LRQ_SIZE-1:0]   i_lrq_resolve_index_oh,
  input  logic                  i_lrq_free,
  output issue_t                o_replay_issue,
  output logic [ENTRY_SIZE-1:0] o_replay_index_oh
);

  localparam int unsigned IDX_W = (ENTRY_SIZE > 1) ? $clog2(ENTRY_SIZE) : 1;

  logic [ENTRY_SIZE-1:0] w_ready, w_cand, w_grant_oh;
  logic                  w_grant_vld;
  logic [IDX_W-1:0]      w_grant_idx, w_scan, r_rr_ptr, w_rr_ptr_next;
  issue_t                w_grant_issue;

  for (genvar g = 0; g < ENTRY_SIZE; g++) begin : g_entry
    msrh_lsu_replay_entry #(
      .LRQ_SIZE    (LRQ_SIZE),
      .BACKOFF_CYC (BACKOFF_CYC)
    ) u_entry (
      .i_clk                  (i_clk),
      .i_reset_n              (i_reset_n),
      .i_clear                (i_entry_clear[g]),
      .i_ex1_haz_vld          (i_ex1_haz_vld & i_ex1_index_oh[g]),
      .i_ex2_update           (i_ex2_update & i_ex2_index_oh[g]),
      .i_ex2_hazard_typ       (i_ex2_hazard_typ),
      .i_ex2_lrq_index_oh     (i_ex2_lrq_index_oh),
      .i_tlb_resolve          (i_tlb_resolve),
      .i_lrq_resolve_vld      (i_lrq_resolve_vld),
      .i_lrq_resolve_index_oh (i_lrq_resolve_index_oh),
      .i_lrq_free             (i_lrq_free),
      .i_grant                (w_grant_oh[g]),
      .o_ready                (w_ready[g])
    );
  end

  // An entry being killed this cycle must not be replayed.
  assign w_cand = w_ready & ~i_entry_clear;

  always_comb begin
    w_grant_oh  = '0;
    w_grant_idx = '0;
    w_grant_vld = 1'b0;
    w_scan      = '0;
    for (int unsigned k = 0; k < ENTRY_SIZE; k++) begin
      w_scan = IDX_W'((32'(r_rr_ptr) + k) % ENTRY_SIZE);
      if (!w_grant_vld && w_cand[w_scan]) begin
        w_grant_vld        = 1'b1;
        w_grant_idx        = w_scan;
        w_grant_oh[w_scan] = 1'b1;
      end
    end
  end

  always_comb begin
    w_rr_ptr_next = r_rr_ptr;
    if (w_grant_vld) begin
      w_rr_ptr_next = (32'(w_grant_idx) == ENTRY_SIZE - 1) ? '0 : w_grant_idx + 1'b1;
    end
  end

  always_comb begin
    w_grant_issue = '0;
    if (w_grant_vld) begin
      w_grant_issue       = i_entry_issue[w_grant_idx];
      w_grant_issue.valid = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rr_ptr          <= '0;
      o_replay_issue    <= '0;
      o_replay_index_oh <= '0;
    end else begin
      r_rr_ptr          <= w_rr_ptr_next;
      o_replay_issue    <= w_grant_issue;
      o_replay_index_oh <= w_grant_oh;
    end
  end

  a_replay_onehot0 : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    $onehot0(o_replay_index_oh));

  a_grant_was_ready : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (w_grant_oh & ~w_ready) == '0);

  a_ex1_ex2_disjoint : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(i_ex1_haz_vld && i_ex2_update && |(i_ex1_index_oh & i_ex2_index_oh)));

endmodule
